// File: rtl/clock_switch_pkg.sv
// Shared types and helpers for the clock-switch sequencer.
// CLKSW_DWELL_EN adds the post-switch DWELL state.
package clock_switch_pkg;

  localparam logic [1:0] SRC_800M  = 2'b00;
  localparam logic [1:0] SRC_500M  = 2'b01;
  localparam logic [1:0] SRC_1000M = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    SETTLE,
`ifdef CLKSW_DWELL_EN
    ACK,
    DWELL
`else
    ACK
`endif
  } state_e;

  // Fold the unused code 2'b11 onto the 1000 MHz source.
  function automatic logic [1:0] norm_src(input logic [1:0] s);
    return (s == 2'b11) ? SRC_1000M : s;
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The pointer moves past the served requester on adv_i.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  input  logic [NREQ-1:0] adv_gnt_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            any_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // First active request at or after the pointer wins.
  always_comb begin
    logic found;
    int   j;
    found     = 1'b0;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
    any_o = found;
  end

  // Next pointer: one past the requester just acknowledged.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (adv_gnt_i[i]) ptr_d = IW'((i + 1) % NREQ);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/clock_switch_ctrl.sv
// Sequencer driving clk_sel of the three-source glitch-free clock switch.
// Optional macro CLKSW_DWELL_EN enforces a dwell after each real switch.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_sel,
  output logic [NREQ-1:0]   ack,
  output logic [1:0]        clk_sel,
  output logic [1:0]        cur_src,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] g_q, g_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      clk_sel_q, clk_sel_d;
  logic [1:0]      cur_src_q, cur_src_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            adv;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            any;

`ifdef CLKSW_DWELL_EN
  localparam int DW = $clog2(DWELL_CYC + 1);
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          sw_q, sw_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .adv_i     (adv),
    .adv_gnt_i (g_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gidx),
    .any_o     (any)
  );

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    clk_sel_d = clk_sel_q;
    cur_src_d = cur_src_q;
    ack_d     = '0;
    adv       = 1'b0;
`ifdef CLKSW_DWELL_EN
    dcnt_d    = dcnt_q;
    sw_d      = sw_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          g_d     = gnt;
          tgt_d   = norm_src(req_sel[2*int'(gidx) +: 2]);
          state_d = SWITCH;
`ifdef CLKSW_DWELL_EN
          sw_d    = 1'b0;
`endif
        end
      end
      // Same-source requests pass through without touching clk_sel.
      SWITCH: begin
        if (tgt_q != cur_src_q) begin
          clk_sel_d = tgt_q;
          cnt_d     = CW'(SETTLE_CYC - 1);
          state_d   = SETTLE;
`ifdef CLKSW_DWELL_EN
          sw_d      = 1'b1;
`endif
        end else begin
          state_d = ACK;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACK: begin
        adv     = 1'b1;
        state_d = IDLE;
`ifdef CLKSW_DWELL_EN
        if (sw_q) begin
          dcnt_d  = DW'(DWELL_CYC - 1);
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (dcnt_q == '0) state_d = IDLE;
        else              dcnt_d  = dcnt_q - 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACK) begin
      ack_d     = g_q;
      cur_src_d = tgt_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      tgt_q     <= SRC_800M;
      cnt_q     <= '0;
      clk_sel_q <= SRC_800M;
      cur_src_q <= SRC_800M;
      ack_q     <= '0;
      busy_q    <= 1'b0;
`ifdef CLKSW_DWELL_EN
      dcnt_q    <= '0;
      sw_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      clk_sel_q <= clk_sel_d;
      cur_src_q <= cur_src_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
`ifdef CLKSW_DWELL_EN
      dcnt_q    <= dcnt_d;
      sw_q      <= sw_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign clk_sel = clk_sel_q;
  assign cur_src = cur_src_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Scoreboard bench for clock_switch_ctrl.
// Expected acks come from a round-robin/timing model of the sequencer.
module tb_clock_switch_ctrl;

  localparam int NREQ = 4;
  localparam int S    = 8;
  localparam int D    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] req_sel = '0;
  logic [NREQ-1:0]   ack;
  logic [1:0]        clk_sel;
  logic [1:0]        cur_src;
  logic              busy;

  clock_switch_ctrl #(
    .NREQ(NREQ), .SETTLE_CYC(S), .DWELL_CYC(D)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
    .ack(ack), .clk_sel(clk_sel), .cur_src(cur_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] src;
    bit         sw;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   nack   = 0;
  int   last_chg = -100;
  logic [1:0] prev_sel = 2'b00;

  // model state
  int         mptr = 0;
  logic [1:0] mcur = 2'b00;
  int         mready = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  endtask

  // monitor: track clk_sel changes and score every ack
  always @(negedge clk) begin
    if (clk_sel != prev_sel) last_chg = cyc;
    prev_sel = clk_sel;
    if (!rst && ack != '0) begin
      nack++;
      if (q.size() == 0) begin
        chk("unexpected_ack", int'(ack), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_vec", int'(ack), 1 << e.idx);
        chk("ack_cycle", cyc, e.cyc);
        chk("cur_src", int'(cur_src), int'(e.src));
        chk("clk_sel", int'(clk_sel), int'(e.src));
        chk("busy_in_ack", int'(busy), 1);
        if (e.sw) chk("sel_change_cyc", last_chg, e.cyc - S);
        else chk("no_toggle", int'(last_chg <= e.cyc - 2), 1);
      end
    end
  end

  task automatic model_reset();
    mptr   = 0;
    mcur   = 2'b00;
    mready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Issue one set of simultaneous requests and hold each until acked.
  task automatic episode(input logic [NREQ-1:0] mask,
                         input logic [2*NREQ-1:0] sels);
    int k, k0, a, guard;
    int order[$];
    bit changed;
    logic [1:0] t;
    k = (cyc + 1 > mready) ? cyc + 1 : mready;
    k0 = k;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (mptr + i) % NREQ;
      if (mask[j]) order.push_back(j);
    end
    foreach (order[n]) begin
      exp_t e;
      t = sels[2*order[n] +: 2];
      if (t == 2'b11) t = 2'b10;
      e.idx = order[n];
      e.src = t;
      e.sw  = (t != mcur);
      a = k + (e.sw ? S + 1 : 1);
      e.cyc = a;
      q.push_back(e);
      mcur = t;
      mptr = (order[n] + 1) % NREQ;
`ifdef CLKSW_DWELL_EN
      k = a + 2 + (e.sw ? D : 0);
`else
      k = a + 2;
`endif
    end
    mready = k;
    req_sel = sels;
    req = mask;
    guard = 0;
    changed = 0;
    while (req != '0 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!changed && cyc >= k0) begin
        req_sel[2*order[0] +: 2] = 2'($urandom);
        changed = 1;
      end
      req = req & ~ack;
    end
    if (req != '0) begin
      chk("episode_timeout", int'(req), 0);
      summary();
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_clk_sel", int'(clk_sel), 0);
    chk("rst_cur_src", int'(cur_src), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    episode(4'b0001, 8'b00_00_00_01);
    episode(4'b0100, 8'b00_01_00_00);
    episode(4'b0001, 8'b00_00_00_11);
    chk("norm_cur_src", int'(cur_src), 2);

    do_reset();
    episode(4'b1010, 8'b00_00_10_00);

    // reset in the middle of SETTLE
    req_sel = 8'b00_00_00_10;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    base = nack;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_clk_sel", int'(clk_sel), 0);
    chk("mid_rst_cur_src", int'(cur_src), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ack", int'(ack), 0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    model_reset();
    repeat (S + 6) @(negedge clk);
    chk("no_ack_after_abort", nack, base);

    for (int n = 0; n < 40; n++) begin
      episode(4'($urandom_range(1, 15)), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    summary();
  end

endmodule
